// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: byte-enabled 1W/2R register file with write bypass and sequenced clear
module reg_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wAddr,
    input  logic [DATA_W-1:0]   wData,
    input  logic [DATA_W/8-1:0] wBe,
    input  logic                re0,
    input  logic                re1,
    input  logic [ADDR_W-1:0]   rAddr0,
    input  logic [ADDR_W-1:0]   rAddr1,
    output logic [DATA_W-1:0]   rData0,
    output logic [DATA_W-1:0]   rData1,
    output logic                rValid0,
    output logic                rValid1,
    input  logic                clr,
    output logic                busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] merged, rd0, rd1;
    logic              wr_en, zeroing;
    assign busy    = (state == CLEAR);
    assign zeroing = (state == CLEAR) || clr;
    assign wr_en   = (state == IDLE) && we && !clr && !((ZERO_REG != 0) && (wAddr == '0));
    assign rd0 = (zeroing || ((ZERO_REG != 0) && (rAddr0 == '0))) ? '0 :
                 (wr_en && (wAddr == rAddr0)) ? merged : regs[rAddr0];
    assign rd1 = (zeroing || ((ZERO_REG != 0) && (rAddr1 == '0))) ? '0 :
                 (wr_en && (wAddr == rAddr1)) ? merged : regs[rAddr1];
    // state register and clear counter; counter wraps to 0 on the last clear edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
        end
    end
    // next state: clr starts a sweep from IDLE, the sweep ends after the last address
    always_comb begin
        state_nx = state;
        if (state == IDLE && clr)
            state_nx = CLEAR;
        else if (state == CLEAR && (&cnt))
            state_nx = IDLE;
    end
    // write data merged byte-wise over the current contents, shared by write and bypass
    always_comb begin
        merged = regs[wAddr];
        for (int i = 0; i < NB; i++)
            if (wBe[i]) merged[8*i +: 8] = wData[8*i +: 8];
    end
    // storage: clear sweep has priority, writes only when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_en) begin
            regs[wAddr] <= merged;
        end
    end
    // registered read ports; data holds when not requested
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rData0  <= '0;
            rData1  <= '0;
            rValid0 <= 1'b0;
            rValid1 <= 1'b0;
        end else begin
            if (re0) rData0 <= rd0;
            if (re1) rData1 <= rd1;
            rValid0 <= re0;
            rValid1 <= re1;
        end
    end
endmodule
